counter_ctrl: RTL

COUNTER_CTRL -- requirements
Module: counter_ctrl

---
 rtl/counter_ctrl_if.sv | 30 +++
 rtl/counter_ctrl.sv | 99 +++++++++
 2 files changed

// File: rtl/counter_ctrl_if.sv
// Control/status bundle between counter_ctrl and the agent that drives it.
// Carries the run request (start/abort/init_val/reps), the counter carry-out,
// and the counter strobes plus run status back out.
//   master : run requester plus the controlled counter (drives start, abort, init_val, reps, co)
//   slave  : counter_ctrl (drives cnt_en, cnt_load, cnt_in, busy, done, pass_cnt)
interface counter_ctrl_if #(
    parameter int W = 3
);
    logic         start;
    logic         abort;
    logic [W-1:0] init_val;
    logic [1:0]   reps;
    logic         co;
    logic         cnt_en;
    logic         cnt_load;
    logic [W-1:0] cnt_in;
    logic         busy;
    logic         done;
    logic [1:0]   pass_cnt;

    modport master (
        output start, abort, init_val, reps, co,
        input  cnt_en, cnt_load, cnt_in, busy, done, pass_cnt
    );

    modport slave (
        input  start, abort, init_val, reps, co,
        output cnt_en, cnt_load, cnt_in, busy, done, pass_cnt
    );
endinterface

// File: rtl/counter_ctrl.sv
// Purpose: sequences an external W-bit up-counter through reps+1 load/count passes.
// Latency: done pulses (reps+1)*(1 + 2^W - init_val) + 1 cycles after the start edge.
// Backpressure: none; start is ignored while busy, abort cancels a run on the next edge.
// Ports:
//   clk  - rising-edge clock
//   rst  - asynchronous active-low reset
//   bus  - counter_ctrl_if.slave: start/abort/init_val/reps/co in,
//          cnt_en/cnt_load/cnt_in/busy/done/pass_cnt out
module counter_ctrl #(
    parameter int W = 3
) (
    input  logic           clk,
    input  logic           rst,
    counter_ctrl_if.slave  bus
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_LOAD  = 2'd1,
        S_COUNT = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t       state_q;
    state_t       state_d;
    logic [W-1:0] cnt_in_q;
    logic [1:0]   reps_q;
    logic [1:0]   pass_q;

    logic start_acc;
    logic pass_end;

    // A start is only honoured from IDLE, and a simultaneous abort vetoes it.
    assign start_acc = (state_q == S_IDLE) && bus.start && !bus.abort;
    // End of a pass: carry seen while counting and not pre-empted by abort.
    assign pass_end  = (state_q == S_COUNT) && bus.co && !bus.abort;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (start_acc) begin
                    state_d = S_LOAD;
                end
            end
            S_LOAD: begin
                state_d = bus.abort ? S_IDLE : S_COUNT;
            end
            S_COUNT: begin
                if (bus.abort) begin
                    state_d = S_IDLE;
                end else if (bus.co) begin
                    // pass_q never exceeds reps_q during a run, so < selects "more passes left".
                    state_d = (pass_q < reps_q) ? S_LOAD : S_DONE;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Run parameters are captured once per run so mid-run input changes are inert;
    // on abort everything simply holds.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_in_q <= '0;
            reps_q   <= '0;
            pass_q   <= '0;
        end else if (start_acc) begin
            cnt_in_q <= bus.init_val;
            reps_q   <= bus.reps;
            pass_q   <= '0;
        end else if (pass_end) begin
            // Wraps to 0 after the fourth pass when reps = 3.
            pass_q   <= pass_q + 2'd1;
        end
    end

    // Moore outputs: strobes depend on state alone, so load and enable are exclusive.
    assign bus.cnt_load = (state_q == S_LOAD);
    assign bus.cnt_en   = (state_q == S_COUNT);
    assign bus.busy     = (state_q != S_IDLE);
    assign bus.done     = (state_q == S_DONE);
    assign bus.cnt_in   = cnt_in_q;
    assign bus.pass_cnt = pass_q;

endmodule
